// File: rtl/nv_nvdla_cmac_pkg.sv
// ---------------------------------------------------------------------------
// nv_nvdla_cmac_pkg
// Shared definitions for the CMAC layer controller: sequencer state
// encoding, packet-info bit positions and the default MAC pipeline depth.
// ---------------------------------------------------------------------------
package nv_nvdla_cmac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACTIVE = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_DONE   = 3'd3,
    ST_HOLD   = 3'd4
  } cmac_ctrl_state_e;

  localparam int PD_W            = 9;
  localparam int PD_STRIPE_END   = 7;
  localparam int PD_LAYER_END    = 8;
  localparam int MAC_LATENCY_DFLT = 7;

endpackage

// File: rtl/nv_nvdla_cmac_slcg_en.sv
// ---------------------------------------------------------------------------
// nv_nvdla_cmac_slcg_en
// Owns the MAC-cell clock-enable: the layer enable bit, the post-done HOLD
// counter and the registered override OR that drives slcg_op_en.
//
// Ports:
//   nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//   en_set_i      : layer armed, raise the enable
//   en_clr_i      : layer aborted, drop the enable
//   hold_load_i   : sequencer in DONE, load the hold counter
//   hold_run_i    : sequencer in HOLD, count down
//   clk_ovr_i     : any clock override / gating-disable active
//   hold_expire_o : last HOLD cycle, sequencer returns to IDLE
//   slcg_op_en_o  : per-domain clock enable (registered)
// ---------------------------------------------------------------------------
module nv_nvdla_cmac_slcg_en #(
  parameter int SLCG_NUM  = 3,
  parameter int SLCG_HOLD = 4
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rstn,
  input  logic                en_set_i,
  input  logic                en_clr_i,
  input  logic                hold_load_i,
  input  logic                hold_run_i,
  input  logic                clk_ovr_i,
  output logic                hold_expire_o,
  output logic [SLCG_NUM-1:0] slcg_op_en_o
);

  localparam int HOLD_W = (SLCG_HOLD < 1) ? 1 : $clog2(SLCG_HOLD + 1);

  logic              en_q, en_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [SLCG_NUM-1:0] slcg_q;

  // The counter reaches zero on the same edge that releases the enable, so
  // the domains stay clocked for SLCG_HOLD cycles after the done cycle.
  assign hold_expire_o = hold_run_i && (hold_cnt_q <= HOLD_W'(1));

  // NOTE: every combinational output gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    en_d       = en_q;
    hold_cnt_d = hold_cnt_q;
    if (en_set_i)                        en_d = 1'b1;
    else if (en_clr_i || hold_expire_o)  en_d = 1'b0;
    if (hold_load_i)                     hold_cnt_d = HOLD_W'(SLCG_HOLD);
    else if (hold_run_i && hold_cnt_q != '0) hold_cnt_d = hold_cnt_q - HOLD_W'(1);
  end

  // NOTE: sequential state is updated with non-blocking assignments so all
  // flops sample their inputs from the same pre-edge values.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      en_q       <= 1'b0;
      hold_cnt_q <= '0;
      slcg_q     <= '0;
    end else begin
      en_q       <= en_d;
      hold_cnt_q <= hold_cnt_d;
      // Next-state enable feeds the output flop directly: one register from
      // arm/override inputs to the gating cells.
      slcg_q     <= {SLCG_NUM{en_d}} | {SLCG_NUM{clk_ovr_i}};
    end
  end

  assign slcg_op_en_o = slcg_q;

endmodule

// File: rtl/nv_nvdla_cmac_layer_ctrl.sv
// ---------------------------------------------------------------------------
// nv_nvdla_cmac_layer_ctrl
// Per-layer sequencer for the convolution MAC array. Arms on an op_en
// rising edge, qualifies packets while ACTIVE, counts stripes, waits for the
// MAC pipeline to drain, pulses dp2reg_done and releases the SLCG enables.
//
// Optional feature (macro NVDLA_CMAC_PERF_EN): perf_active_cyc and
// perf_idle_beat performance counters.
//
// Ports:
//   nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//   reg2dp_op_en       : layer enable level from register block
//   reg2dp_conv_mode   : 0=direct, 1=winograd, sampled at arm
//   sc2mac_dat_pvld/pd : packet valid / info ([7]=stripe_end, [8]=layer_end)
//   *_clk_ovr_on_sync, tmc2slcg_disable_clock_gating : clock overrides
//   dat_pvld_qual      : pvld gated by ACTIVE
//   conv_mode_lat      : conv mode latched at arm
//   slcg_op_en         : per-domain clock enable
//   dp2reg_done        : one-cycle layer-done pulse
//   stripe_cnt         : stripes completed in this layer (saturating)
//   busy               : sequencer not IDLE
// ---------------------------------------------------------------------------
module nv_nvdla_cmac_layer_ctrl
  import nv_nvdla_cmac_pkg::*;
#(
  parameter int MAC_LATENCY  = MAC_LATENCY_DFLT,
  parameter int SLCG_NUM     = 3,
  parameter int SLCG_HOLD    = 4,
  parameter int STRIPE_CNT_W = 16
) (
  input  logic                    nvdla_core_clk,
  input  logic                    nvdla_core_rstn,
  input  logic                    reg2dp_op_en,
  input  logic                    reg2dp_conv_mode,
  input  logic                    sc2mac_dat_pvld,
  input  logic [PD_W-1:0]         sc2mac_dat_pd,
  input  logic                    dla_clk_ovr_on_sync,
  input  logic                    global_clk_ovr_on_sync,
  input  logic                    tmc2slcg_disable_clock_gating,
  output logic                    dat_pvld_qual,
  output logic                    conv_mode_lat,
  output logic [SLCG_NUM-1:0]     slcg_op_en,
  output logic                    dp2reg_done,
  output logic [STRIPE_CNT_W-1:0] stripe_cnt,
  output logic                    busy
`ifdef NVDLA_CMAC_PERF_EN
  ,
  output logic [31:0]             perf_active_cyc,
  output logic [31:0]             perf_idle_beat
`endif
);

  localparam int DRAIN_W = 4;

  cmac_ctrl_state_e          state_q, state_d;
  logic                      op_en_d_q;
  logic                      conv_mode_q;
  logic [STRIPE_CNT_W-1:0]   stripe_cnt_q, stripe_cnt_d;
  logic [DRAIN_W-1:0]        drain_cnt_q, drain_cnt_d;
  logic                      hold_expire;

  logic arm, arm_go, abort, in_active, in_drain;
  logic stripe_hit, layer_hit;
  logic unused_pd;

  assign arm        = reg2dp_op_en & ~op_en_d_q;
  assign in_active  = (state_q == ST_ACTIVE);
  assign in_drain   = (state_q == ST_DRAIN);
  assign arm_go     = (state_q == ST_IDLE) & arm;
  assign abort      = (in_active | in_drain) & ~reg2dp_op_en;
  // A layer_end beat closes its stripe too, even without the stripe_end bit.
  assign stripe_hit = in_active & sc2mac_dat_pvld &
                      (sc2mac_dat_pd[PD_STRIPE_END] | sc2mac_dat_pd[PD_LAYER_END]);
  assign layer_hit  = in_active & sc2mac_dat_pvld & sc2mac_dat_pd[PD_LAYER_END];
  assign unused_pd  = ^sc2mac_dat_pd[PD_STRIPE_END-1:0];

  // ---- FSM: state register ----
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) state_q <= ST_IDLE;
    else                  state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (arm)                          state_d = ST_ACTIVE;
      ST_ACTIVE: if (!reg2dp_op_en)                state_d = ST_IDLE;
                 else if (layer_hit)               state_d = ST_DRAIN;
      ST_DRAIN:  if (!reg2dp_op_en)                state_d = ST_IDLE;
                 else if (drain_cnt_q <= DRAIN_W'(1)) state_d = ST_DONE;
      ST_DONE:                                     state_d = ST_HOLD;
      ST_HOLD:   if (hold_expire)                  state_d = ST_IDLE;
      default:                                     state_d = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    dat_pvld_qual = in_active & sc2mac_dat_pvld;
    dp2reg_done   = (state_q == ST_DONE);
    busy          = (state_q != ST_IDLE);
  end

  // ---- Layer datapath ----
  always_comb begin
    stripe_cnt_d = stripe_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    if (arm_go)                                     stripe_cnt_d = '0;
    else if (stripe_hit && stripe_cnt_q != '1)      stripe_cnt_d = stripe_cnt_q + 1'b1;
    if (layer_hit)                                  drain_cnt_d = DRAIN_W'(MAC_LATENCY);
    else if (in_drain && drain_cnt_q != '0)         drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      op_en_d_q    <= 1'b0;
      conv_mode_q  <= 1'b0;
      stripe_cnt_q <= '0;
      drain_cnt_q  <= '0;
    end else begin
      op_en_d_q    <= reg2dp_op_en;
      if (arm_go) conv_mode_q <= reg2dp_conv_mode;
      stripe_cnt_q <= stripe_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
    end
  end

  assign conv_mode_lat = conv_mode_q;
  assign stripe_cnt    = stripe_cnt_q;

  // ---- Clock-enable domain control ----
  nv_nvdla_cmac_slcg_en #(
    .SLCG_NUM  (SLCG_NUM),
    .SLCG_HOLD (SLCG_HOLD)
  ) u_slcg_en (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .en_set_i        (arm_go),
    .en_clr_i        (abort),
    .hold_load_i     (state_q == ST_DONE),
    .hold_run_i      (state_q == ST_HOLD),
    .clk_ovr_i       (dla_clk_ovr_on_sync | global_clk_ovr_on_sync |
                      tmc2slcg_disable_clock_gating),
    .hold_expire_o   (hold_expire),
    .slcg_op_en_o    (slcg_op_en)
  );

`ifdef NVDLA_CMAC_PERF_EN
  // Counters restart on arm and otherwise hold, so values survive past done.
  logic [31:0] perf_active_q, perf_idle_q;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      perf_active_q <= '0;
      perf_idle_q   <= '0;
    end else if (arm_go) begin
      perf_active_q <= '0;
      perf_idle_q   <= '0;
    end else if (in_active) begin
      if (perf_active_q != '1)                   perf_active_q <= perf_active_q + 32'd1;
      if (!sc2mac_dat_pvld && perf_idle_q != '1) perf_idle_q   <= perf_idle_q + 32'd1;
    end
  end

  assign perf_active_cyc = perf_active_q;
  assign perf_idle_beat  = perf_idle_q;
`endif

endmodule
